// File: rtl/prio_enc_pkg.sv
// Shared definitions for the serial priority encoder.
//   state_t   : controller state encoding (IDLE, SCAN)
//   clog2     : ceiling log2, usable in constant expressions
//   idx_width : index width for a given request width, never below 1
package prio_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  function automatic int idx_width(input int width);
    return (clog2(width) < 1) ? 1 : clog2(width);
  endfunction

endpackage : prio_enc_pkg

// File: rtl/prio_enc_comb.sv
// Purely combinational priority encoder over a WIDTH-bit vector.
// Ports:
//   vec         in  WIDTH  vector to encode
//   idx         out IDX_W  index of the winning set bit (0 when vec is zero)
//   found       out 1      at least one bit of vec is set
//   at_most_one out 1      vec has zero or one bit set
// MSB_FIRST=1 picks the highest set bit, MSB_FIRST=0 the lowest.
module prio_enc_comb
  import prio_enc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             at_most_one
);

  // The scan direction is chosen so that the winning bit is the one visited
  // last; later assignments override earlier ones.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  assign found = |vec;

  // Clearing the lowest set bit leaves zero exactly when popcount <= 1.
  assign at_most_one = ((vec & (vec - WIDTH'(1))) == '0);

endmodule : prio_enc_comb

// File: rtl/prio_enc_serial.sv
// Serial priority encoder: accepts a WIDTH-bit request vector over a
// valid/ready handshake and emits the index of every set bit, one beat per
// handshake, in priority order. An all-zero vector yields a single beat with
// out_none set.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_vec     in   request vector, sampled on input handshake
//   in_valid   in   in_vec is valid
//   in_ready   out  block can accept a vector this cycle
//   out_idx    out  index of the current set bit
//   out_valid  out  out_idx/out_last/out_none are valid
//   out_ready  in   downstream accepts the current beat
//   out_last   out  current beat is the final one for this vector
//   out_none   out  accepted vector was all-zero
module prio_enc_serial
  import prio_enc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_none
);

  state_t           state, state_n;
  logic [WIDTH-1:0] pending, pending_n;
  logic             zero_flag, zero_flag_n;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;
  logic             enc_one;

  logic             in_fire;
  logic             out_fire;

  prio_enc_comb #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_enc (
    .vec        (pending),
    .idx        (enc_idx),
    .found      (enc_found),
    .at_most_one(enc_one)
  );

  // Outputs come from registered state only; in_vec feeds next-state logic
  // and nothing else. Gating with the state keeps them at zero in IDLE.
  assign out_valid = (state == SCAN);
  assign out_idx   = (out_valid && enc_found) ? enc_idx : '0;
  assign out_last  = out_valid && enc_one;
  assign out_none  = out_valid && zero_flag;

  // A new vector may enter while the final beat of the current one is being
  // taken, so one-hot streams run at one vector per cycle.
  assign in_ready = !rst && ((state == IDLE) || (out_last && out_ready));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_n     = state;
    pending_n   = pending;
    zero_flag_n = zero_flag;
    unique case (state)
      IDLE: begin
        if (in_fire) begin
          pending_n   = in_vec;
          zero_flag_n = (in_vec == '0);
          state_n     = SCAN;
        end
      end
      SCAN: begin
        if (out_fire) begin
          pending_n = pending & ~(WIDTH'(1) << out_idx);
          if (out_last) begin
            if (in_fire) begin
              pending_n   = in_vec;
              zero_flag_n = (in_vec == '0);
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      // NOTE: pending is a plain register, not a memory, so it is cleared on
      // reset; a stale vector must never survive into the next IDLE.
      state     <= IDLE;
      pending   <= '0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      zero_flag <= zero_flag_n;
    end
  end

endmodule : prio_enc_serial
